// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: PC register, instruction memory, decode and redirect signals.
interface fetch_ctrl_if;
    logic        pc_write;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport slave (
        input  pc_cur, imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_target,
        output pc_write, pc_next, imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport master (
        output pc_cur, imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_target,
        input  pc_write, pc_next, imem_req, imem_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: issues one memory request at a time,
// presents the fetched instruction to decode, and handles redirects by squashing stale data.
module fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         res,
    fetch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic        squash_q,   squash_d;
    logic [31:0] req_pc_q,   req_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q,    if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic        pc_write_s;
    logic [31:0] pc_next_s;
    logic        imem_req_s;
    logic [31:0] target_s;

    // Next-state and PC/memory strobe logic; strobes are suppressed while reset is asserted.
    always_comb begin
        state_d    = state_q;
        squash_d   = squash_q;
        req_pc_d   = req_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        pc_write_s = 1'b0;
        pc_next_s  = bus.pc_cur + 32'd4;
        imem_req_s = 1'b0;
        target_s   = {bus.redirect_target[31:2], 2'b00};

        if (res) begin
            case (state_q)
                IDLE: begin
                    state_d = REQ;
                    if (bus.redirect) begin
                        pc_write_s = 1'b1;
                        pc_next_s  = target_s;
                        if_valid_d = 1'b0;
                    end else begin
                        if_valid_d = if_valid_q;
                    end
                end
                REQ: begin
                    imem_req_s = 1'b1;
                    if_valid_d = 1'b0;
                    if (bus.redirect) begin
                        pc_write_s = 1'b1;
                        pc_next_s  = target_s;
                        if (bus.imem_gnt) begin
                            // The granted fetch belongs to the old path; drop its data later.
                            squash_d = 1'b1;
                            req_pc_d = bus.pc_cur;
                            state_d  = WAIT;
                        end else begin
                            state_d = REQ;
                        end
                    end else if (bus.imem_gnt) begin
                        pc_write_s = 1'b1;
                        req_pc_d   = bus.pc_cur;
                        state_d    = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
                WAIT: begin
                    if (bus.redirect) begin
                        pc_write_s = 1'b1;
                        pc_next_s  = target_s;
                        if (bus.imem_rvalid) begin
                            squash_d = 1'b0;
                            state_d  = REQ;
                        end else begin
                            squash_d = 1'b1;
                        end
                    end else if (bus.imem_rvalid) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = REQ;
                        end else begin
                            if_valid_d = 1'b1;
                            if_pc_d    = req_pc_q;
                            if_instr_d = bus.imem_rdata;
                            state_d    = bus.stall ? HOLD : REQ;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    if (bus.redirect) begin
                        pc_write_s = 1'b1;
                        pc_next_s  = target_s;
                        if_valid_d = 1'b0;
                        state_d    = REQ;
                    end else if (!bus.stall) begin
                        if_valid_d = 1'b0;
                        state_d    = REQ;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = IDLE;
        end
    end

    // State and presentation registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q    <= IDLE;
            squash_q   <= 1'b0;
            req_pc_q   <= 32'd0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            squash_q   <= squash_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign bus.pc_write  = pc_write_s;
    assign bus.pc_next   = pc_next_s;
    assign bus.imem_req  = imem_req_s;
    assign bus.imem_addr = bus.pc_cur;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl: each row is one cycle of inputs and the
// outputs expected during that cycle, followed by a hand-written reset-mid-WAIT sequence.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic res;
    fetch_ctrl_if bus ();

    fetch_ctrl #(.NOP_INSTR(NOP)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        res;
        logic [31:0] pc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        stl;
        logic        rd;
        logic [31:0] tgt;
        logic        e_pw;
        logic [31:0] e_pn;
        logic        e_req;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    function automatic vec_t mk(logic r, logic [31:0] pc, logic gnt, logic rv, logic [31:0] rdata,
                                logic stl, logic rd, logic [31:0] tgt, logic pw, logic [31:0] pn,
                                logic req, logic iv, logic [31:0] ipc, logic [31:0] ins);
        vec_t v;
        v.res = r;  v.pc = pc;  v.gnt = gnt;  v.rv = rv;  v.rdata = rdata;
        v.stl = stl; v.rd = rd; v.tgt = tgt;
        v.e_pw = pw; v.e_pn = pn; v.e_req = req; v.e_iv = iv; v.e_ipc = ipc; v.e_ins = ins;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
            miscompares++;
        end
    endtask

    task automatic drive(vec_t v);
        res                 = v.res;
        bus.pc_cur          = v.pc;
        bus.imem_gnt        = v.gnt;
        bus.imem_rvalid     = v.rv;
        bus.imem_rdata      = v.rdata;
        bus.stall           = v.stl;
        bus.redirect        = v.rd;
        bus.redirect_target = v.tgt;
    endtask

    // Drive one cycle just after the edge, check mid-cycle, then let the next edge happen.
    task automatic apply(string tag, vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        #3;
        applied++;
        chk($sformatf("%s pc_write", tag), {31'd0, bus.pc_write}, {31'd0, v.e_pw});
        if (v.e_pw) chk($sformatf("%s pc_next", tag), bus.pc_next, v.e_pn);
        chk($sformatf("%s imem_req", tag), {31'd0, bus.imem_req}, {31'd0, v.e_req});
        if (v.e_req) chk($sformatf("%s imem_addr", tag), bus.imem_addr, v.pc);
        chk($sformatf("%s if_valid", tag), {31'd0, bus.if_valid}, {31'd0, v.e_iv});
        chk($sformatf("%s if_pc", tag), bus.if_pc, v.e_ipc);
        chk($sformatf("%s if_instr", tag), bus.if_instr, v.e_ins);
    endtask

    initial begin
        drive(mk(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0,
                 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, NOP));
        repeat (2) @(posedge clk);

        // Reset release and first fetch
        vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b1, 32'h4, 1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0050_0093));
        vecs.push_back(mk(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0050_0093));
        // Stall during capture, held for three cycles
        vecs.push_back(mk(1'b1, 32'h8, 1'b0, 1'b1, 32'h00A0_0113, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0050_0093));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'h00A0_0113));
        vecs.push_back(mk(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'h00A0_0113));
        vecs.push_back(mk(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h00A0_0113));
        // Redirect in WAIT: stale data squashed
        vecs.push_back(mk(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC, 1'b1, 1'b0, 32'h4, 32'h00A0_0113));
        vecs.push_back(mk(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h103, 1'b1, 32'h100, 1'b0, 1'b0, 32'h4, 32'h00A0_0113));
        vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 32'h00A0_0113));
        vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h00A0_0113));
        // Redirect together with grant in REQ
        vecs.push_back(mk(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 32'h4, 32'h00A0_0113));
        vecs.push_back(mk(1'b1, 32'h200, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 32'h00A0_0113));
        vecs.push_back(mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h00A0_0113));
        // PC wrap at the top of the address space
        vecs.push_back(mk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h00A0_0113));
        vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 32'h00A0_0113));
        // Redirect in REQ without grant, then redirect in WAIT coinciding with rvalid
        vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h33));
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h33));
        vecs.push_back(mk(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h33));
        vecs.push_back(mk(1'b1, 32'h44, 1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 32'h81, 1'b1, 32'h80, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h33));
        // Redirect in HOLD wins over stall
        vecs.push_back(mk(1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h84, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h33));
        vecs.push_back(mk(1'b1, 32'h84, 1'b0, 1'b1, 32'h66, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h33));
        vecs.push_back(mk(1'b1, 32'h84, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 32'h80, 32'h66));
        vecs.push_back(mk(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h66));

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Reset mid-WAIT with rvalid during and after reset, then redirect in IDLE
        apply("rst_grant", mk(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                              1'b1, 32'h304, 1'b1, 1'b0, 32'h80, 32'h66));
        apply("rst_assert", mk(1'b0, 32'h304, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0, 32'h0,
                               1'b0, 32'h0, 1'b0, 1'b0, 32'h80, 32'h66));
        apply("rst_late_rv", mk(1'b1, 32'h304, 1'b0, 1'b1, 32'h88, 1'b0, 1'b1, 32'h500,
                                1'b1, 32'h500, 1'b0, 1'b0, 32'h0, NOP));
        apply("rst_restart", mk(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                                1'b0, 32'h0, 1'b1, 1'b0, 32'h0, NOP));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the value of if_instr while no valid instruction is held.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port res, input, 1, a synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port pc_cur, input, 32, the current PC register output.
REQ-005 The block SHALL have port pc_write, output, 1, the PC register write enable.
REQ-006 The block SHALL have port pc_next, output, 32, the PC register write data.
REQ-007 The block SHALL have port imem_req, output, 1, the instruction memory request.
REQ-008 The block SHALL have port imem_addr, output, 32, the request address.
REQ-009 The block SHALL have port imem_gnt, input, 1, the request accepted by memory.
REQ-010 The block SHALL have port imem_rvalid, input, 1, the read data valid.
REQ-011 The block SHALL have port imem_rdata, input, 32, the read data.
REQ-012 The block SHALL have port stall, input, 1, meaning decode cannot accept an instruction.
REQ-013 The block SHALL have port redirect, input, 1, a branch or jump taken.
REQ-014 The block SHALL have port redirect_target, input, 32, the new fetch PC.
REQ-015 The block SHALL have port if_valid, output, 1, meaning a fetched instruction is presented.
REQ-016 The block SHALL have port if_pc, output, 32, the PC of the presented instruction.
REQ-017 The block SHALL have port if_instr, output, 32, the presented instruction.

Function
REQ-018 The block SHALL use the FSM states IDLE, REQ, WAIT and HOLD, with only one memory request outstanding at a time.
REQ-019 The FSM SHALL go from IDLE to REQ unconditionally on the next clock edge.
REQ-020 In REQ, the block SHALL drive imem_req=1 and imem_addr=pc_cur combinationally.
REQ-021 In REQ, when imem_gnt=1, the block SHALL latch req_pc=pc_cur, pulse pc_write=1 with pc_next=pc_cur+4 for that cycle, and go to WAIT.
REQ-022 The PC increment SHALL be modulo 2^32, so 32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-023 In WAIT, the block SHALL hold imem_req=0.
REQ-024 In WAIT, when imem_rvalid=1 and the squash flag is clear, the block SHALL register if_instr=imem_rdata, if_pc=req_pc and if_valid=1 on the next edge.
REQ-025 From WAIT, on the valid capture of REQ-024, the FSM SHALL go to HOLD if stall=1, else to REQ.
REQ-026 if_valid SHALL stay 1 while the state is HOLD, and if_pc and if_instr SHALL stay stable throughout HOLD.
REQ-027 In HOLD, when stall=0, the FSM SHALL go to REQ and if_valid SHALL drop on that edge.
REQ-028 In REQ, if_valid SHALL be 1 for exactly the one cycle after each capture unless stall=1 holds it per REQ-025.
REQ-029 Every pc_write caused by a redirect SHALL use pc_next={redirect_target[31:2],2'b00}.
REQ-030 Redirect in REQ without imem_gnt: the block SHALL pulse pc_write with the target and stay in REQ; imem_addr follows pc_cur on the next cycle.
REQ-031 Redirect in REQ with imem_gnt in the same cycle: the redirect write SHALL take priority over the +4 write, the squash flag SHALL be set, and the FSM SHALL go to WAIT.
REQ-032 Redirect in WAIT: the block SHALL pulse pc_write with the target and set the squash flag, unless imem_rvalid=1 in that cycle, in which case that data SHALL be dropped and the FSM SHALL go to REQ.
REQ-033 In WAIT with the squash flag set, imem_rvalid=1 SHALL clear the flag, leave if_valid at 0 and send the FSM to REQ.
REQ-034 Redirect in HOLD or in IDLE: the block SHALL pulse pc_write with the target and clear if_valid on the next edge; in HOLD the FSM SHALL then go to REQ.
REQ-035 Redirect SHALL take priority over stall in every state.
REQ-036 pc_write SHALL be 0 in all cases other than REQ-021 and REQ-029 to REQ-034.

Reset
REQ-037 While res=0 at a clock edge, the block SHALL enter IDLE and clear the squash flag.
REQ-038 While res=0 at a clock edge, if_valid SHALL be 0, if_pc SHALL be 0 and if_instr SHALL be NOP_INSTR.
REQ-039 During reset, pc_write=0 and imem_req=0; reset SHALL override any in-flight transaction, and a late imem_rvalid after reset SHALL be ignored.

Verification
REQ-040 The bench SHALL cover reset release: pc_cur=0, gnt=1 one cycle later, rvalid with rdata=32'h00500093 -> pc_write with pc_next=4, then if_valid=1, if_pc=0, if_instr=32'h00500093.
REQ-041 The bench SHALL cover stall: stall=1 during capture for 3 cycles -> if_valid and if_instr held for 3 cycles, no imem_req; stall=0 -> REQ next cycle.
REQ-042 The bench SHALL cover redirect in WAIT: target=32'h0000_0103 -> pc_next=32'h0000_0100, returned data dropped (if_valid=0), next imem_addr=32'h100.
REQ-043 The bench SHALL cover redirect together with gnt in REQ -> single pc_write carrying the target, not pc_cur+4.
REQ-044 The bench SHALL cover wrap: pc_cur=32'hFFFF_FFFC granted -> pc_next=32'h0000_0000.
REQ-045 The bench SHALL cover reset mid-WAIT: res=0, then rvalid arrives -> if_valid stays 0, if_instr=NOP_INSTR, FSM restarts from IDLE.
